// File: rtl/to_8bit_mux_if.sv
// Byte-stream bus for to_8bit_mux: parallel sources, mode select, enable and serialized byte out.
// TO8BIT_VALID_EN adds the dataValid/frameStart sideband.
interface to_8bit_mux_if;
    logic        enb;
    logic [7:0]  dataIn;
    logic [15:0] dataIn16;
    logic [31:0] dataIn32;
    logic [1:0]  dataS;
    logic [7:0]  dataOut;
`ifdef TO8BIT_VALID_EN
    logic        dataValid;
    logic        frameStart;

    modport master (output enb, dataIn, dataIn16, dataIn32, dataS,
                    input  dataOut, dataValid, frameStart);
    modport slave  (input  enb, dataIn, dataIn16, dataIn32, dataS,
                    output dataOut, dataValid, frameStart);
`else
    modport master (output enb, dataIn, dataIn16, dataIn32, dataS,
                    input  dataOut);
    modport slave  (input  enb, dataIn, dataIn16, dataIn32, dataS,
                    output dataOut);
`endif
endinterface

// File: rtl/to_8bit_mux.sv
// Serializes an 8/16/32-bit source into one byte per clock, MSB byte first.
// Optional macro TO8BIT_VALID_EN adds registered dataValid/frameStart outputs.
module to_8bit_mux #(
    parameter logic [7:0] IDLE_BYTE = 8'h00
) (
    input logic          clk,
    input logic          rst,
    to_8bit_mux_if.slave bus
);

    logic [1:0]  cnt;
    logic [1:0]  cntNext;
    logic [1:0]  prevS;
    logic [31:0] hold;
    logic [31:0] holdNext;
    logic [7:0]  outReg;
    logic [7:0]  outNext;
    logic        frameBegin;

    // A mode change restarts the frame in the same cycle, whatever cnt holds.
    assign frameBegin = (cnt == 2'd0) || (bus.dataS != prevS);

    always_comb begin
        cntNext  = 2'd0;
        holdNext = hold;
        outNext  = IDLE_BYTE;
        case (bus.dataS)
            2'b00: begin
                outNext = bus.dataIn;
            end
            2'b01: begin
                if (frameBegin) begin
                    holdNext = {hold[31:16], bus.dataIn16};
                    outNext  = bus.dataIn16[15:8];
                    cntNext  = 2'd1;
                end else begin
                    outNext  = hold[7:0];
                end
            end
            2'b10: begin
                if (frameBegin) begin
                    holdNext = bus.dataIn32;
                    outNext  = bus.dataIn32[31:24];
                    cntNext  = 2'd1;
                end else begin
                    cntNext = cnt + 2'd1;
                    case (cnt)
                        2'd1:    outNext = hold[23:16];
                        2'd2:    outNext = hold[15:8];
                        default: outNext = hold[7:0];
                    endcase
                end
            end
            default: begin
                outNext = IDLE_BYTE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= 2'd0;
            hold   <= 32'd0;
            prevS  <= 2'b00;
            outReg <= 8'h00;
        end else if (bus.enb) begin
            cnt    <= cntNext;
            hold   <= holdNext;
            prevS  <= bus.dataS;
            outReg <= outNext;
        end
    end

    assign bus.dataOut = outReg;

`ifdef TO8BIT_VALID_EN
    logic validReg;
    logic validNext;
    logic fsReg;
    logic fsNext;

    always_comb begin
        validNext = (bus.dataS != 2'b11);
        fsNext    = (bus.dataS == 2'b00) ||
                    (((bus.dataS == 2'b01) || (bus.dataS == 2'b10)) && frameBegin);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            validReg <= 1'b0;
            fsReg    <= 1'b0;
        end else if (bus.enb) begin
            validReg <= validNext;
            fsReg    <= fsNext;
        end
    end

    assign bus.dataValid  = validReg;
    assign bus.frameStart = fsReg;
`endif

endmodule

// File: tb/tb_to_8bit_mux.sv
// Scoreboard bench for to_8bit_mux: stimulus pushes hand-computed bytes, a monitor pops and compares.
// Sideband checks are active when TO8BIT_VALID_EN is defined.
module tb_to_8bit_mux;

    typedef struct {
        int         idx;
        logic [7:0] out;
        logic       v;
        logic       f;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   stepIdx;
    exp_t sbQ[$];

    to_8bit_mux_if bus ();

    to_8bit_mux #(.IDLE_BYTE(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // One enabled/disabled cycle of stimulus plus the byte expected after the coming edge.
    task automatic applyStimulus(input logic en, input logic [1:0] s, input logic [7:0] d8,
                                 input logic [15:0] d16, input logic [31:0] d32,
                                 input logic [7:0] expOut, input logic expV, input logic expF);
        exp_t e;
        @(negedge clk);
        bus.enb      = en;
        bus.dataS    = s;
        bus.dataIn   = d8;
        bus.dataIn16 = d16;
        bus.dataIn32 = d32;
        e.idx = stepIdx;
        e.out = expOut;
        e.v   = expV;
        e.f   = expF;
        sbQ.push_back(e);
        stepIdx++;
    endtask

    task automatic resetMidCycle(input string name);
        @(posedge clk);
        #3;
        bus.enb = 1'b0;
        rst     = 1'b0;
        #1;
        checkOutput(name, {24'd0, bus.dataOut}, 32'h0);
`ifdef TO8BIT_VALID_EN
        checkOutput({name, "_valid"}, {31'd0, bus.dataValid}, 32'h0);
        checkOutput({name, "_fs"}, {31'd0, bus.frameStart}, 32'h0);
`endif
        @(negedge clk);
        rst = 1'b1;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #2;
        if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkOutput($sformatf("byte%0d", e.idx), {24'd0, bus.dataOut}, {24'd0, e.out});
`ifdef TO8BIT_VALID_EN
            checkOutput($sformatf("valid%0d", e.idx), {31'd0, bus.dataValid}, {31'd0, e.v});
            checkOutput($sformatf("fs%0d", e.idx), {31'd0, bus.frameStart}, {31'd0, e.f});
`endif
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] seq8 [7];
        checks  = 0;
        errors  = 0;
        stepIdx = 0;
        seq8    = '{8'hff, 8'h00, 8'hf0, 8'h0f, 8'h9a, 8'h6d, 8'h9a};
        rst          = 1'b1;
        bus.enb      = 1'b0;
        bus.dataS    = 2'b00;
        bus.dataIn   = 8'h00;
        bus.dataIn16 = 16'h0000;
        bus.dataIn32 = 32'h0;
        #3;
        rst = 1'b0;
        #1;
        checkOutput("resetInitial", {24'd0, bus.dataOut}, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        applyStimulus(1, 2'b00, 8'h5a, 16'h0, 32'h0, 8'h5a, 1, 1);
        resetMidCycle("resetMid8");

        // 8-bit passthrough with one cycle of latency
        foreach (seq8[i])
            applyStimulus(1, 2'b00, seq8[i], 16'h0, 32'h0, seq8[i], 1, 1);

        // 16-bit frames; the second word's source changes mid-frame and must be ignored
        applyStimulus(1, 2'b01, 8'h00, 16'had43, 32'h0, 8'had, 1, 1);
        applyStimulus(1, 2'b01, 8'h00, 16'had43, 32'h0, 8'h43, 1, 0);
        applyStimulus(1, 2'b01, 8'h00, 16'h543f, 32'h0, 8'h54, 1, 1);
        applyStimulus(1, 2'b01, 8'h00, 16'hffff, 32'h0, 8'h3f, 1, 0);
        applyStimulus(1, 2'b01, 8'h00, 16'h7d5a, 32'h0, 8'h7d, 1, 1);
        applyStimulus(1, 2'b01, 8'h00, 16'h7d5a, 32'h0, 8'h5a, 1, 0);

        // 32-bit frames; first word's source is disturbed mid-frame
        applyStimulus(1, 2'b10, 8'h00, 16'h0, 32'h95fdad43, 8'h95, 1, 1);
        applyStimulus(1, 2'b10, 8'h00, 16'h0, 32'h00000000, 8'hfd, 1, 0);
        applyStimulus(1, 2'b10, 8'h00, 16'h0, 32'h12345678, 8'had, 1, 0);
        applyStimulus(1, 2'b10, 8'h00, 16'h0, 32'h12345678, 8'h43, 1, 0);
        applyStimulus(1, 2'b10, 8'h00, 16'h0, 32'h94d5543f, 8'h94, 1, 1);
        applyStimulus(1, 2'b10, 8'h00, 16'h0, 32'h94d5543f, 8'hd5, 1, 0);
        applyStimulus(1, 2'b10, 8'h00, 16'h0, 32'h94d5543f, 8'h54, 1, 0);
        applyStimulus(1, 2'b10, 8'h00, 16'h0, 32'h94d5543f, 8'h3f, 1, 0);
        applyStimulus(1, 2'b10, 8'h00, 16'h0, 32'h0378fdae, 8'h03, 1, 1);
        applyStimulus(1, 2'b10, 8'h00, 16'h0, 32'h0378fdae, 8'h78, 1, 0);
        applyStimulus(1, 2'b10, 8'h00, 16'h0, 32'h0378fdae, 8'hfd, 1, 0);
        applyStimulus(1, 2'b10, 8'h00, 16'h0, 32'h0378fdae, 8'hae, 1, 0);

        // Enable low after byte fd: everything holds, inputs (including dataS) ignored
        applyStimulus(1, 2'b10, 8'h00, 16'h0, 32'h95fdad43, 8'h95, 1, 1);
        applyStimulus(1, 2'b10, 8'h00, 16'h0, 32'h95fdad43, 8'hfd, 1, 0);
        for (int i = 0; i < 5; i++)
            applyStimulus(0, 2'b11, 8'hff, 16'hffff, 32'hffffffff, 8'hfd, 1, 0);
        applyStimulus(1, 2'b10, 8'h00, 16'h0, 32'h95fdad43, 8'had, 1, 0);
        applyStimulus(1, 2'b10, 8'h00, 16'h0, 32'h95fdad43, 8'h43, 1, 0);

        // Mode change 10->01 at cnt=2, then reserved mode
        applyStimulus(1, 2'b10, 8'h00, 16'h0,    32'ha1b2c3d4, 8'ha1, 1, 1);
        applyStimulus(1, 2'b10, 8'h00, 16'h0,    32'ha1b2c3d4, 8'hb2, 1, 0);
        applyStimulus(1, 2'b01, 8'h00, 16'hc0de, 32'ha1b2c3d4, 8'hc0, 1, 1);
        applyStimulus(1, 2'b01, 8'h00, 16'h0000, 32'ha1b2c3d4, 8'hde, 1, 0);
        applyStimulus(1, 2'b11, 8'hff, 16'hffff, 32'hffffffff, 8'h00, 0, 0);
        applyStimulus(1, 2'b11, 8'h77, 16'h7777, 32'h77777777, 8'h00, 0, 0);

        // Reset mid-frame at cnt=1; the frame restarts from the current word's MSB
        applyStimulus(1, 2'b10, 8'h00, 16'h0, 32'hdeadbeef, 8'hde, 1, 1);
        resetMidCycle("resetMid32");
        applyStimulus(1, 2'b10, 8'h00, 16'h0, 32'hdeadbeef, 8'hde, 1, 1);
        applyStimulus(1, 2'b10, 8'h00, 16'h0, 32'hdeadbeef, 8'had, 1, 0);
        applyStimulus(1, 2'b10, 8'h00, 16'h0, 32'hdeadbeef, 8'hbe, 1, 0);
        applyStimulus(1, 2'b10, 8'h00, 16'h0, 32'hdeadbeef, 8'hef, 1, 0);

        @(posedge clk);
        #3;
        checkOutput("scoreboardDrained", sbQ.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/to_8bit_mux.md
Name: to_8bit_mux

Overview:
- Width converter in front of the 8-bit byte-stream path. Selects one of three parallel sources (8-, 16- or 32-bit) with a 2-bit mode input and emits it as one byte per clock.
- A single clock is used. Wide words are captured once per frame and serialized MSB byte first.
- The clock-divider block is no longer needed: one clock drives the whole block and an internal byte counter replaces the divided clocks.

Parameters:
- IDLE_BYTE, 8'h00, value driven on dataOut in reserved mode 2'b11.

Ports:
- clk  in  1  byte clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- enb  in  1  enable; low freezes all state and holds dataOut.
- dataIn  in  8  8-bit source, mode 2'b00.
- dataIn16  in  16  16-bit source, mode 2'b01.
- dataIn32  in  32  32-bit source, mode 2'b10.
- dataS  in  2  mode select: 00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = reserved.
- dataOut  out  8  registered output byte.

Behaviour:
- Reset (rst=0, asynchronous): dataOut=8'h00, byte counter cnt=0, 32-bit holding register hold=0, previous-mode register prevS=2'b00. All clear immediately, regardless of clk. Normal operation resumes on the first rising edge after rst returns high.
- enb=0: cnt, hold, prevS and dataOut keep their values; inputs are ignored.
- Frame start condition: cnt==0, or dataS!=prevS (mode change). On a mode change, cnt is forced to 0 and a new frame starts in the same cycle. prevS <= dataS every enabled cycle.
- Mode 00:
  - dataOut <= dataIn every enabled cycle; 1-cycle latency.
  - cnt stays 0.
- Mode 01, frame start:
  - hold[15:0] <= dataIn16, dataOut <= dataIn16[15:8], cnt <= 1.
- Mode 01, cnt==1:
  - dataOut <= hold[7:0], cnt <= 0.
  - dataIn16 is sampled only at frame start; changes mid-frame are ignored.
- Mode 10, frame start:
  - hold <= dataIn32, dataOut <= dataIn32[31:24], cnt <= 1.
- Mode 10, cnt 1, 2, 3:
  - dataOut <= hold[23:16], hold[15:8], hold[7:0] respectively.
  - cnt wraps 3 -> 0, and the next cycle samples a new word.
- Mode 11: dataOut <= IDLE_BYTE, cnt <= 0.
- Throughput:
  - 16-bit: one word every 2 cycles.
  - 32-bit: one word every 4 cycles.
  - Upstream must present the next word before the cycle in which cnt returns to 0.
- dataOut is always a flop output; there is no combinational path from any input to dataOut.

Optional Feature:
- Macro TO8BIT_VALID_EN.
- Defined:
  - Adds outputs dataValid (1 bit) and frameStart (1 bit), both registered alongside dataOut.
  - dataValid=1 when an enabled cycle loaded a real byte (modes 00/01/10); 0 in mode 11 and after reset.
  - frameStart=1 on the byte that carries a word's MSB; always 1 in mode 00.
  - With enb=0 both hold their values. Reset clears both to 0.
- Undefined: neither port exists; behaviour is otherwise identical.

Test Plan:
- Reset then 8-bit: rst=0 mid-cycle -> dataOut=00 at once. Release; dataS=00, dataIn=ff,00,f0,0f,9a,6d,9a on consecutive cycles -> dataOut repeats the same sequence delayed by one cycle.
- 16-bit: dataS=01, dataIn16=ad43 then 543f then 7d5a, each held 2 cycles -> dataOut ad,43,54,3f,7d,5a. The switch 00->01 starts a frame on the first 01 cycle.
- 32-bit: dataS=10, dataIn32=95fdad43, 94d5543f, 0378fdae, each held 4 cycles -> dataOut 95,fd,ad,43,94,d5,54,3f,03,78,fd,ae. Changing dataIn32 mid-frame does not alter the current frame.
- Enable: during a 32-bit frame after byte fd, enb=0 for 5 cycles -> dataOut holds fd. Re-enable -> ad,43 continue.
- Mode change and reserved mode: switch 10->01 at cnt=2 -> the next byte is the new dataIn16[15:8]. dataS=11 -> dataOut=IDLE_BYTE (00).
- Reset mid-frame: rst=0 at cnt=1 in mode 10 -> dataOut=00 and cnt=0 asynchronously. After release, the first byte is the MSB of the current dataIn32.
